pe_array_os_ctrl: RTL and testbench
===================================

Name: pe_array_os_ctrl

Overview:
Sequencer for the PE_Array systolic array in output-stationary (OS) mode. It accepts a start command with an inner dimension K, then consumes K operand beats through a valid/ready stream. Each beat is one column of A (ROWS elements) plus one row of B (COLS elements). The block applies the diagonal input skew, waits for the wavefront to flush, and drains the ROWS×COLS result through a valid/ready result stream, one row per beat. It sits between the on-chip operand buffers and the PE_Array instance, and owns that instance's data_flow, load, drain, A and B inputs.

Parameters:
DATA_WIDTH, 8, operand element width; results are 2*DATA_WIDTH.
ROWS, 8, array rows; must match PE_Array.
COLS, 8, array columns; must match PE_Array.
K_MAX, 256, maximum inner dimension; KW = clog2(K_MAX+1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle command pulse; honoured only in IDLE
k_len  in  KW  inner dimension; sampled on an honoured start; legal range 1..K_MAX
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result beat is accepted
op_valid  in  1  operand beat valid
op_ready  out  1  operand beat accepted when op_valid && op_ready
op_a  in  ROWS*DATA_WIDTH  A column; element i drives array row i
op_b  in  COLS*DATA_WIDTH  B row; element j drives array column j
pe_data_flow  out  1  tied 0 (OS mode)
pe_load  out  1  tied 0
pe_drain  out  1  drain strobe to the array
pe_a  out  ROWS*DATA_WIDTH  skewed A to PE_Array.A
pe_b  out  COLS*DATA_WIDTH  skewed B to PE_Array.B
pe_c  in  COLS*2*DATA_WIDTH  PE_Array.C_out
res_valid  out  1  result row valid
res_ready  in  1  result row accepted when res_valid && res_ready
res_data  out  COLS*2*DATA_WIDTH  one result row
res_row  out  clog2(ROWS)  matrix row index of res_data

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: all outputs 0, FSM in IDLE, all counters 0, skew registers 0.
- FSM: IDLE -> FEED -> FLUSH -> DRAIN -> IDLE.
- IDLE: start=1 latches k_len and goes to FEED. A start with k_len=0 is ignored. A start in any other state is ignored.
- FEED: op_ready=1. Each accepted beat increments kcnt. The accepted op_a/op_b enter skew stage 0. A cycle with no accepted beat injects zeros. When kcnt reaches k_len the FSM goes to FLUSH and op_ready drops in the same cycle the last beat is accepted.
- Skew:
  - A element i is delayed i cycles; B element j is delayed j cycles. Row 0 and column 0 have zero delay (combinational from the accepted beat, or zero).
  - Skew delay lines are implemented as shift registers of zero-filled stages.
  - A zero injection contributes product 0, so input gaps and stalls never corrupt the accumulators.
- FLUSH: zeros are injected for exactly ROWS+COLS-2 cycles, counted by fcnt. The FSM then goes to DRAIN. A value of 0 (ROWS=COLS=1) skips FLUSH.
- DRAIN:
  - pe_drain=1 only in cycles where no result is pending or the pending result is accepted.
  - Each drain cycle shifts the array down one row. pe_c is captured into the res_data register the following cycle and res_valid is set.
  - The first row out is matrix row ROWS-1; res_row counts down to 0.
  - If res_ready=0 while res_valid=1, pe_drain is held 0. The array holds its state because zero inputs are still fed.
  - After ROWS results are accepted: done pulses for 1 cycle, the FSM returns to IDLE, and busy falls in the same cycle done pulses.
- Arithmetic: the block performs no arithmetic. Operand and result values pass through unmodified.
- Reset mid-operation: returns to IDLE next edge and clears the skew lines, res_valid and the counters. A partial accumulation left inside PE_Array is cleared by the PE's own reset. rst is wired to PE_Array reset through an inverter at the parent.
- Simultaneous op_valid and FSM transition: the last beat is accepted and the FSM moves to FLUSH in the same cycle. No beat is accepted in FLUSH.

Decomposition:
- Shared package: the FSM state enum (S_IDLE, S_FEED, S_FLUSH, S_DRAIN), and localparams FLUSH_CYCLES = ROWS+COLS-2 and KW.
- One natural sub-module: skew_line (parameter DEPTH, DATA_WIDTH). It is a zero-reset shift register with an inject-zero input, instantiated per row and per column of pe_a and pe_b.

Test Plan:
1. ROWS=COLS=8, K=8, A=identity, B[k][j]=k*8+j -> 8 res beats with rows 7..0; res_data equals the matching B row; done pulses once.
2. K=1, op_a all 3, op_b all -2 -> every result element is -6, sign-extended to 16 bits (0xFFFA).
3. K=4 with op_valid toggling 1,0,0,1,... -> results equal the gap-free run; op_ready is low after the 4th beat.
4. K=8 with res_ready low for 5 cycles at the 3rd result -> res_valid and res_data are held stable; pe_drain=0 during the stall; all 8 rows are correct and in order.
5. start pulsed during FEED with a different k_len -> ignored; beat count still equals the original K.
6. rst asserted mid-FLUSH -> next cycle busy=0 and res_valid=0; a new start with K=2 produces correct results.

Source files
------------

// File: rtl/pe_array_os_ctrl_pkg.sv
// rtl/pe_array_os_ctrl_pkg.sv - shared types and constants for the OS-mode PE array sequencer
// Contents: FSM state enum, default array geometry, flush length helper.
package pe_array_os_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN
  } state_t;

  localparam int DEF_ROWS  = 8;
  localparam int DEF_COLS  = 8;
  localparam int DEF_K_MAX = 256;

  // Wavefront flush length and k_len width for the default geometry.
  localparam int FLUSH_CYCLES = DEF_ROWS + DEF_COLS - 2;
  localparam int KW           = $clog2(DEF_K_MAX + 1);

  // The last operand reaches PE(ROWS-1, COLS-1) this many cycles after entry.
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

endpackage

// File: rtl/pe_array_os_ctrl_skew.sv
// rtl/pe_array_os_ctrl_skew.sv - zero-filled delay line used for the diagonal operand skew
// Ports: clk, rst (sync active-high), zero (inject 0 instead of din), din, dout (din delayed DEPTH cycles).
module skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  zero,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) stages[s] <= '0;
    end else begin
      stages[0] <= zero ? '0 : din;
      for (int s = 1; s < DEPTH; s++) stages[s] <= stages[s-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/pe_array_os_ctrl.sv
// rtl/pe_array_os_ctrl.sv - output-stationary sequencer for the PE_Array systolic array
// Ports: clk/rst; start/k_len/busy/done command; op_* operand stream in;
//        pe_* drive and result from PE_Array; res_* result row stream out.
module pe_array_os_ctrl
  import pe_array_os_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int K_MAX      = DEF_K_MAX,
  localparam int KLW       = $clog2(K_MAX + 1),
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KLW-1:0]               k_len,
  output logic                         busy,
  output logic                         done,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]   op_a,
  input  logic [COLS*DATA_WIDTH-1:0]   op_b,
  output logic                         pe_data_flow,
  output logic                         pe_load,
  output logic                         pe_drain,
  output logic [ROWS*DATA_WIDTH-1:0]   pe_a,
  output logic [COLS*DATA_WIDTH-1:0]   pe_b,
  input  logic [COLS*2*DATA_WIDTH-1:0] pe_c,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [COLS*2*DATA_WIDTH-1:0] res_data,
  output logic [RW-1:0]                res_row
);

  localparam int FLUSH_N = flush_len(ROWS, COLS);
  localparam int FW      = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;
  localparam int DCW     = $clog2(ROWS + 1);

  state_t         state;
  logic [KLW-1:0] k_reg;
  logic [KLW-1:0] kcnt;
  logic [FW-1:0]  fcnt;
  logic [DCW-1:0] dcnt;
  logic           drain_d;
  logic           accept;
  logic           inject_zero;

  assign accept       = op_valid && op_ready;
  assign inject_zero  = !accept;
  assign pe_data_flow = 1'b0;
  assign pe_load      = 1'b0;

  // A drained row needs one cycle to appear on pe_c, so a new drain waits for
  // that capture and for the output register to be free or leaving this cycle.
  assign pe_drain = (state == S_DRAIN) && (int'(dcnt) < ROWS) && !drain_d &&
                    (!res_valid || res_ready);

  for (genvar i = 0; i < ROWS; i++) begin : g_a
    if (i == 0) begin : g_direct
      assign pe_a[0 +: DATA_WIDTH] = accept ? op_a[0 +: DATA_WIDTH] : '0;
    end else begin : g_line
      skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_skew (
        .clk  (clk),
        .rst  (rst),
        .zero (inject_zero),
        .din  (op_a[i*DATA_WIDTH +: DATA_WIDTH]),
        .dout (pe_a[i*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b
    if (j == 0) begin : g_direct
      assign pe_b[0 +: DATA_WIDTH] = accept ? op_b[0 +: DATA_WIDTH] : '0;
    end else begin : g_line
      skew_line #(.DEPTH(j), .DATA_WIDTH(DATA_WIDTH)) u_skew (
        .clk  (clk),
        .rst  (rst),
        .zero (inject_zero),
        .din  (op_b[j*DATA_WIDTH +: DATA_WIDTH]),
        .dout (pe_b[j*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k_reg     <= '0;
      kcnt      <= '0;
      fcnt      <= '0;
      dcnt      <= '0;
      drain_d   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
    end else begin
      done    <= 1'b0;
      drain_d <= pe_drain;
      case (state)
        S_IDLE: begin
          if (start && (k_len != '0)) begin
            k_reg    <= k_len;
            kcnt     <= '0;
            op_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= S_FEED;
          end
        end
        S_FEED: begin
          if (accept) begin
            kcnt <= kcnt + KLW'(1);
            if (kcnt + KLW'(1) == k_reg) begin
              op_ready <= 1'b0;
              fcnt     <= '0;
              dcnt     <= '0;
              state    <= (FLUSH_N == 0) ? S_DRAIN : S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (int'(fcnt) == FLUSH_N - 1) state <= S_DRAIN;
          else                           fcnt  <= fcnt + FW'(1);
        end
        S_DRAIN: begin
          if (pe_drain) dcnt <= dcnt + DCW'(1);
          // dcnt already counts the drain being captured, so rows come out ROWS-1..0.
          if (drain_d) begin
            res_data  <= pe_c;
            res_valid <= 1'b1;
            res_row   <= RW'(ROWS - int'(dcnt));
          end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            if (res_row == '0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_os_ctrl.sv
// tb/tb_pe_array_os_ctrl.sv - directed self-checking bench for pe_array_os_ctrl with an OS PE_Array model
module tb_pe_array_os_ctrl;
  import pe_array_os_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int R  = 8;
  localparam int C  = 8;
  localparam int RW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [KW-1:0]  k_len = '0;
  logic           busy, done;
  logic           op_valid = 1'b0;
  logic           op_ready;
  logic [R*DW-1:0] op_a = '0;
  logic [C*DW-1:0] op_b = '0;
  logic           pe_data_flow, pe_load, pe_drain;
  logic [R*DW-1:0] pe_a;
  logic [C*DW-1:0] pe_b;
  logic [C*2*DW-1:0] pe_c;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [C*2*DW-1:0] res_data;
  logic [RW-1:0]  res_row;

  always #5 clk = ~clk;

  pe_array_os_ctrl #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .K_MAX(256)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pe_data_flow(pe_data_flow), .pe_load(pe_load), .pe_drain(pe_drain),
    .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_row(res_row)
  );

  // Output-stationary PE_Array model: A moves right, B moves down, drain shifts rows down.
  logic signed [7:0]  a_in [R][C];
  logic signed [7:0]  b_in [R][C];
  logic signed [7:0]  a_r  [R][C];
  logic signed [7:0]  b_r  [R][C];
  logic signed [15:0] acc  [R][C];
  logic [127:0]       c_out;

  assign pe_c = c_out;

  always_comb begin
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        a_in[i][j] = '0;
        b_in[i][j] = '0;
      end
    for (int i = 0; i < R; i++) begin
      a_in[i][0] = pe_a[i*DW +: DW];
      for (int j = 1; j < C; j++) a_in[i][j] = a_r[i][j-1];
    end
    for (int j = 0; j < C; j++) begin
      b_in[0][j] = pe_b[j*DW +: DW];
      for (int i = 1; i < R; i++) b_in[i][j] = b_r[i-1][j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) begin
          a_r[i][j] <= '0;
          b_r[i][j] <= '0;
          acc[i][j] <= '0;
        end
      c_out <= '0;
    end else begin
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) begin
          a_r[i][j] <= a_in[i][j];
          b_r[i][j] <= b_in[i][j];
        end
      if (pe_drain) begin
        for (int j = 0; j < C; j++) begin
          c_out[j*16 +: 16] <= acc[R-1][j];
          acc[0][j] <= '0;
          for (int i = 1; i < R; i++) acc[i][j] <= acc[i-1][j];
        end
      end else begin
        for (int i = 0; i < R; i++)
          for (int j = 0; j < C; j++)
            acc[i][j] <= acc[i][j] + 16'(a_in[i][j]) * 16'(b_in[i][j]);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  logic signed [7:0] ma [R][8];
  logic signed [7:0] mb [8][C];
  logic [127:0]      exp_c [R];

  task automatic fill_rand(input int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < R; i++) ma[i][kk] = 8'($urandom);
      for (int j = 0; j < C; j++) mb[kk][j] = 8'($urandom);
    end
  endtask

  task automatic compute_exp(input int k);
    logic signed [15:0] s;
    for (int r = 0; r < R; r++)
      for (int j = 0; j < C; j++) begin
        s = '0;
        for (int kk = 0; kk < k; kk++) s = s + 16'(ma[r][kk]) * 16'(mb[kk][j]);
        exp_c[r][j*16 +: 16] = s;
      end
  endtask

  task automatic do_start(input int k);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    k_len = '0;
  endtask

  task automatic feed(input int k, input int gap, input int restart_at);
    int w;
    check("busy_feed", 128'(busy), 128'(1'b1));
    for (int b = 0; b < k; b++) begin
      op_valid = 1'b1;
      for (int i = 0; i < R; i++) op_a[i*DW +: DW] = ma[i][b];
      for (int j = 0; j < C; j++) op_b[j*DW +: DW] = mb[b][j];
      if (b == restart_at) begin
        start = 1'b1;
        k_len = KW'(k + 3);
      end
      w = 0;
      while (!op_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("op_ready_wait", 128'(op_ready), 128'(1'b1));
      @(negedge clk);
      start    = 1'b0;
      op_valid = 1'b0;
      op_a     = {$urandom, $urandom};
      op_b     = {$urandom, $urandom};
      for (int g = 0; g < gap; g++) @(negedge clk);
    end
    check("op_ready_after_last", 128'(op_ready), 128'(1'b0));
  endtask

  task automatic collect(input int stall_at, input int stall_len);
    int w;
    res_ready = 1'b1;
    for (int idx = 0; idx < R; idx++) begin
      w = 0;
      while (!res_valid && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("res_valid_wait", 128'(res_valid), 128'(1'b1));
      if (!res_valid) return;
      if (idx == stall_at) begin
        res_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          check("stall_valid", 128'(res_valid), 128'(1'b1));
          check("stall_drain", 128'(pe_drain), 128'(1'b0));
          check("stall_data", res_data, exp_c[R-1-idx]);
          @(negedge clk);
        end
        res_ready = 1'b1;
      end
      check("res_row", 128'(res_row), 128'(R - 1 - idx));
      check("res_data", res_data, exp_c[R-1-idx]);
      @(negedge clk);
    end
    check("done_pulse", 128'(done), 128'(1'b1));
    check("busy_low", 128'(busy), 128'(1'b0));
    @(negedge clk);
    check("done_once", 128'(done), 128'(1'b0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_done", 128'(done), 128'(1'b0));
    check("rst_op_ready", 128'(op_ready), 128'(1'b0));
    check("rst_res_valid", 128'(res_valid), 128'(1'b0));
    check("rst_res_data", res_data, 128'(0));
    check("rst_res_row", 128'(res_row), 128'(0));
    check("rst_pe_drain", 128'(pe_drain), 128'(1'b0));
    check("rst_pe_a", 128'(pe_a), 128'(0));
    check("rst_pe_b", 128'(pe_b), 128'(0));
    check("rst_data_flow", 128'(pe_data_flow), 128'(1'b0));
    check("rst_load", 128'(pe_load), 128'(1'b0));
    rst = 1'b0;
    @(negedge clk);

    // start with k_len=0 is ignored
    do_start(0);
    check("k0_ignored", 128'(busy), 128'(1'b0));

    // 1: identity A, B[k][j]=k*8+j -> result rows equal B rows
    for (int i = 0; i < R; i++)
      for (int kk = 0; kk < 8; kk++) ma[i][kk] = (i == kk) ? 8'sd1 : 8'sd0;
    for (int kk = 0; kk < 8; kk++)
      for (int j = 0; j < C; j++) mb[kk][j] = 8'(kk * 8 + j);
    for (int r = 0; r < R; r++)
      for (int j = 0; j < C; j++) exp_c[r][j*16 +: 16] = 16'(r * 8 + j);
    do_start(8);
    feed(8, 0, -1);
    collect(-1, 0);

    // 2: K=1, 3 * -2 = -6 everywhere
    for (int i = 0; i < R; i++) ma[i][0] = 8'sd3;
    for (int j = 0; j < C; j++) mb[0][j] = -8'sd2;
    for (int r = 0; r < R; r++) exp_c[r] = {8{16'hFFFA}};
    do_start(1);
    feed(1, 0, -1);
    collect(-1, 0);

    // 3: K=4 gap-free, then the same operands with two idle cycles between beats
    fill_rand(4);
    compute_exp(4);
    do_start(4);
    feed(4, 0, -1);
    collect(-1, 0);
    do_start(4);
    feed(4, 2, -1);
    collect(-1, 0);

    // 4: K=8 with a 5-cycle stall on the third result
    fill_rand(8);
    compute_exp(8);
    do_start(8);
    feed(8, 0, -1);
    collect(2, 5);

    // 5: start with a different k_len during FEED is ignored
    fill_rand(3);
    compute_exp(3);
    do_start(3);
    feed(3, 0, 1);
    collect(-1, 0);

    // 6: reset during FLUSH, then a fresh K=2 job
    fill_rand(8);
    do_start(8);
    feed(8, 0, -1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 128'(busy), 128'(1'b0));
    check("midrst_res_valid", 128'(res_valid), 128'(1'b0));
    check("midrst_pe_a", 128'(pe_a), 128'(0));
    fill_rand(2);
    compute_exp(2);
    do_start(2);
    feed(2, 0, -1);
    collect(-1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
